// File: rtl/qspi_line_ctrl.sv
// rtl/qspi_line_ctrl.sv - quad-SPI PSRAM line-transfer sequencer for cache fills and writebacks
//
// Runs one quad-SPI transaction per cache request: command, 24-bit line address,
// optional read wait cycles, one line of data, then a chip-select gap.
//
// Ports:
//   clk, reset         clock (one SPI nibble per cycle), synchronous active-high reset
//   push, pull         writeback / fill request from the cache (push wins)
//   tag                line address, latched when a transaction starts
//   dwrite             cache nibble at the cache's current offset (writeback source)
//   dread, wstrobe_d   fill nibble to the cache and its valid strobe
//   rstrobe_d          dwrite consumed this cycle (combinational)
//   busy, done         transaction in progress / one-cycle completion pulse
//   cs_n, sclk_en      PSRAM chip select (active low) and SPI clock enable
//   sio_oe, sio_out    pad drive enable and nibble to the device
//   sio_in             nibble from the device
module qspi_line_ctrl #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 22,
  parameter int DUMMY       = 6,
  parameter int CS_GAP      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   tag,
  input  logic [3:0]                          dwrite,
  output logic [3:0]                          dread,
  output logic                                wstrobe_d,
  output logic                                rstrobe_d,
  output logic                                busy,
  output logic                                done,
  output logic                                cs_n,
  output logic                                sclk_en,
  output logic                                sio_oe,
  output logic [3:0]                          sio_out,
  input  logic [3:0]                          sio_in
);

  localparam int N    = 2 * LINE_LENGTH;
  localparam int AW   = $clog2(LINE_LENGTH);
  localparam int M1   = (N > DUMMY) ? N : DUMMY;
  localparam int M2   = (M1 > CS_GAP) ? M1 : CS_GAP;
  localparam int MAXC = (M2 > 6) ? M2 : 6;
  localparam int CW   = $clog2(MAXC);

  localparam logic [7:0] CMD_WRITE = 8'h38;
  localparam logic [7:0] CMD_READ  = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WAIT,
    DATA,
    GAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_write;
  // Remaining command nibble followed by the address, shifted out MSN first.
  logic [27:0]     shreg;
  logic [23:0]     line_addr;

  assign line_addr = 24'(tag) << AW;

  // The cache presents offset k on dwrite while this is high and advances on the
  // edge; those edges are exactly the ones that load sio_out with line data.
  // Masked by reset so an aborted writeback never advances the cache offset.
  assign rstrobe_d = !reset && is_write &&
                     ((state == ADDR && cnt == CW'(5)) ||
                      (state == DATA && cnt != CW'(N-1)));

  // Outputs are registered for the state being entered, so each one lines up
  // with the SPI cycle it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_write  <= 1'b0;
      shreg     <= '0;
      dread     <= 4'h0;
      wstrobe_d <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cs_n      <= 1'b1;
      sclk_en   <= 1'b0;
      sio_oe    <= 1'b0;
      sio_out   <= 4'h0;
    end else begin
      done      <= 1'b0;
      wstrobe_d <= 1'b0;
      case (state)
        IDLE: begin
          if (push || pull) begin
            state    <= CMD;
            cnt      <= '0;
            is_write <= push;
            busy     <= 1'b1;
            cs_n     <= 1'b0;
            sclk_en  <= 1'b1;
            sio_oe   <= 1'b1;
            sio_out  <= push ? CMD_WRITE[7:4] : CMD_READ[7:4];
            shreg    <= {(push ? CMD_WRITE[3:0] : CMD_READ[3:0]), line_addr};
          end
        end
        CMD, ADDR: begin
          if (state == ADDR && cnt == CW'(5)) begin
            cnt <= '0;
            if (is_write) begin
              state   <= DATA;
              sio_out <= dwrite;
            end else begin
              state   <= (DUMMY > 0) ? WAIT : DATA;
              sio_oe  <= 1'b0;
              sio_out <= 4'h0;
            end
          end else begin
            sio_out <= shreg[27:24];
            shreg   <= shreg << 4;
            if (state == CMD && cnt == CW'(1)) begin
              state <= ADDR;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WAIT: begin
          if (cnt == CW'(DUMMY-1)) begin
            state <= DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (!is_write) begin
            dread     <= sio_in;
            wstrobe_d <= 1'b1;
          end
          if (cnt == CW'(N-1)) begin
            state   <= GAP;
            cnt     <= '0;
            done    <= 1'b1;
            cs_n    <= 1'b1;
            sclk_en <= 1'b0;
            sio_oe  <= 1'b0;
            sio_out <= 4'h0;
          end else begin
            cnt <= cnt + CW'(1);
            if (is_write) begin
              sio_out <= dwrite;
            end
          end
        end
        GAP: begin
          if (cnt == CW'(CS_GAP-1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_line_ctrl.sv
// tb/tb_qspi_line_ctrl.sv - randomized reference-model bench for qspi_line_ctrl
module tb_qspi_line_ctrl;

  localparam int LL     = 4;
  localparam int PA     = 22;
  localparam int DUMMY  = 6;
  localparam int CS_GAP = 2;
  localparam int N      = 2 * LL;
  localparam int AW     = $clog2(LL);
  localparam int TW     = PA - AW;
  // Request-to-request period of the second instance (DUMMY=0, CS_GAP=1) with pull held.
  localparam int P2     = 10 + N;
  localparam int B_T0   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, push, pull;
  logic [TW-1:0] tag;
  logic [3:0]    dwrite, dread, sio_out, sio_in;
  logic          wstrobe_d, rstrobe_d, busy, done, cs_n, sclk_en, sio_oe;

  logic          b_reset, b_push, b_pull;
  logic [TW-1:0] b_tag;
  logic [3:0]    b_dwrite, b_dread, b_sio_out, b_sin;
  logic          b_wstrobe, b_rstrobe, b_busy, b_done, b_cs_n, b_sclk_en, b_sio_oe;

  assign b_push   = 1'b0;
  assign b_dwrite = 4'h0;

  qspi_line_ctrl #(.LINE_LENGTH(LL), .PA(PA), .DUMMY(DUMMY), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset), .push(push), .pull(pull), .tag(tag),
    .dwrite(dwrite), .dread(dread), .wstrobe_d(wstrobe_d), .rstrobe_d(rstrobe_d),
    .busy(busy), .done(done), .cs_n(cs_n), .sclk_en(sclk_en),
    .sio_oe(sio_oe), .sio_out(sio_out), .sio_in(sio_in)
  );

  qspi_line_ctrl #(.LINE_LENGTH(LL), .PA(PA), .DUMMY(0), .CS_GAP(1)) dut_b (
    .clk(clk), .reset(b_reset), .push(b_push), .pull(b_pull), .tag(b_tag),
    .dwrite(b_dwrite), .dread(b_dread), .wstrobe_d(b_wstrobe), .rstrobe_d(b_rstrobe),
    .busy(b_busy), .done(b_done), .cs_n(b_cs_n), .sclk_en(b_sclk_en),
    .sio_oe(b_sio_oe), .sio_out(b_sio_out), .sio_in(b_sin)
  );

  // Cache model: offset advances on each strobe and returns to 0 on any strobe-free cycle.
  logic [3:0]           wline [N];
  logic [3:0]           rline [N];
  logic [$clog2(N)-1:0] wofs, rofs;

  assign dwrite = wline[wofs];

  always_ff @(posedge clk) begin
    wofs <= rstrobe_d ? wofs + 1'b1 : '0;
    if (wstrobe_d) begin
      rline[rofs] <= dread;
      rofs        <= rofs + 1'b1;
    end else begin
      rofs <= '0;
    end
  end

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  bit            m_act = 0;
  bit            m_w   = 0;
  int            m_t0  = 0;
  logic [TW-1:0] m_tag;
  logic [3:0]    m_line [N];
  bit            line_pend = 0;
  bit            sin_seq   = 0;
  logic [3:0]    prev_sin, b_prev_sin;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: finish driving inputs, compare outputs mid-cycle against the
  // transaction model, then advance the model across the clock edge.
  task automatic step();
    int          k, dend, kb;
    logic        e_cs, e_oe, e_rs, e_ws, e_done, e_busy;
    logic [3:0]  e_out;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] gl, el;
    b_reset = (cyc < 3);
    b_pull  = (cyc >= B_T0);
    b_tag   = TW'($urandom);
    b_sin   = 4'($urandom);
    if (sin_seq && m_act) sio_in = 4'(cyc - m_t0 - 15);
    else                  sio_in = 4'($urandom);
    @(negedge clk);
    e_cs = 1'b1; e_oe = 1'b0; e_rs = 1'b0; e_ws = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    e_out = 4'h0; k = 0;
    dend = 8 + (m_w ? 0 : DUMMY) + N;
    if (m_act) begin
      k      = cyc - m_t0;
      cmd    = m_w ? 8'h38 : 8'hEB;
      addr   = 24'(m_tag) << AW;
      e_busy = 1'b1;
      e_cs   = (k > dend);
      e_oe   = (k <= 8) || (m_w && k <= dend);
      if (k <= 2)                e_out = 4'(cmd >> (4 * (2 - k)));
      else if (k <= 8)           e_out = 4'(addr >> (4 * (8 - k)));
      else if (m_w && k <= dend) e_out = wline[k - 9];
      e_rs   = m_w && k >= 8 && k <= 7 + N && !reset;
      e_ws   = !m_w && k >= dend - N + 2 && k <= dend + 1;
      e_done = (k == dend + 1);
    end
    check("cs_n",      32'(cs_n),      32'(e_cs));
    check("sclk_en",   32'(sclk_en),   32'(!e_cs));
    check("busy",      32'(busy),      32'(e_busy));
    check("done",      32'(done),      32'(e_done));
    check("sio_oe",    32'(sio_oe),    32'(e_oe));
    check("rstrobe_d", 32'(rstrobe_d), 32'(e_rs));
    check("wstrobe_d", 32'(wstrobe_d), 32'(e_ws));
    if (e_oe || !m_act) check("sio_out", 32'(sio_out), 32'(e_out));
    if (e_ws) check("dread", 32'(dread), 32'(prev_sin));
    if (line_pend) begin
      gl = '0; el = '0;
      for (int i = 0; i < N; i++) begin
        gl[4*i +: 4] = rline[i];
        el[4*i +: 4] = m_line[i];
      end
      check("fill_line", gl, el);
      line_pend = 0;
    end
    if (cyc > B_T0) begin
      kb = (cyc - B_T0) % P2;
      check("b_busy",    32'(b_busy),    32'(kb != 0));
      check("b_cs_n",    32'(b_cs_n),    32'(!(kb >= 1 && kb <= 8 + N)));
      check("b_wstrobe", 32'(b_wstrobe), 32'(kb >= 10 && kb <= 9 + N));
      check("b_done",    32'(b_done),    32'(kb == 9 + N));
      check("b_rstrobe", 32'(b_rstrobe), 32'(0));
      if (kb >= 10 && kb <= 9 + N) check("b_dread", 32'(b_dread), 32'(b_prev_sin));
    end
    if (m_act && !m_w && k >= dend - N + 1 && k <= dend) m_line[k - (dend - N + 1)] = sio_in;
    if (m_act && e_done && !m_w && !reset) line_pend = 1;
    prev_sin   = sio_in;
    b_prev_sin = b_sin;
    if (reset) begin
      m_act = 0;
    end else if (m_act) begin
      if (k == dend + CS_GAP) m_act = 0;
    end else if (push || pull) begin
      m_act = 1; m_t0 = cyc; m_w = push; m_tag = tag;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pull = 1'b0; tag = '0; sio_in = 4'h0;
    b_reset = 1'b1; b_pull = 1'b0; b_tag = '0; b_sin = 4'h0;
    prev_sin = 4'h0; b_prev_sin = 4'h0;
    for (int i = 0; i < N; i++) begin
      wline[i] = 4'h0; m_line[i] = 4'h0;
    end
    @(posedge clk);
    #1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_dread", 32'(dread), 32'(0));
    repeat (2) step();

    // Fill of tag 0x12345 with device data 0..7.
    sin_seq = 1; tag = TW'(20'h12345); pull = 1'b1;
    step();
    pull = 1'b0; tag = TW'($urandom);
    repeat (30) step();
    sin_seq = 0;

    // Writeback of A,B,C,D,1,2,3,4.
    wline[0] = 4'hA; wline[1] = 4'hB; wline[2] = 4'hC; wline[3] = 4'hD;
    wline[4] = 4'h1; wline[5] = 4'h2; wline[6] = 4'h3; wline[7] = 4'h4;
    tag = TW'($urandom); push = 1'b1;
    step();
    push = 1'b0;
    repeat (25) step();

    // push and pull together; the cache drops push once its writeback is done.
    push = 1'b1; pull = 1'b1; tag = TW'($urandom);
    repeat (9 + N + 1) step();
    push = 1'b0;
    step();
    step();
    pull = 1'b0;
    repeat (30) step();

    // Reset in the middle of a fill, then a normal fill.
    pull = 1'b1; tag = TW'($urandom);
    step();
    pull = 1'b0;
    repeat (11) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    pull = 1'b1; tag = TW'($urandom);
    step();
    pull = 1'b0;
    repeat (30) step();

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if (!m_act) begin
        for (int i = 0; i < N; i++) wline[i] = 4'($urandom);
      end
      push  = ($urandom % 4 == 0);
      pull  = ($urandom % 3 == 0);
      tag   = TW'($urandom);
      reset = ($urandom % 250 == 0);
      step();
    end
    reset = 1'b0; push = 1'b0; pull = 1'b0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
